// File: rtl/intt_pkg.sv
// Shared definitions for the INTT stage controller.
// Holds the default geometry (polynomial length, coefficient width and
// butterfly latency), the stage-controller FSM state encoding, and a helper
// that sizes the stage-index port.
package intt_pkg;

  localparam int LOG_N_DEF  = 10;
  localparam int DATA_W_DEF = 30;
  localparam int BF_LAT_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Width of a stage index: ceil(log2 LOG_N), but never less than one bit.
  function automatic int stage_w(input int log_n);
    return (log_n > 1) ? $clog2(log_n) : 1;
  endfunction

endpackage

// File: rtl/gs_butterfly.sv
// gs_butterfly: Gentleman-Sande butterfly over Z_Q with a fixed pipeline.
//   a = (A + B) mod Q
//   b = ((A - B) * w) mod Q
// Operands are assumed already reduced (< Q). Result appears BF_LAT clocks
// after the operands are presented.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears the pipeline)
//   A, B, w    operands and twiddle
//   a, b       results
module gs_butterfly #(
  parameter int DATA_W = 30,
  parameter int BF_LAT = 3,
  parameter int Q      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  localparam logic [DATA_W:0]     QD = (DATA_W+1)'(Q);
  localparam logic [2*DATA_W-1:0] QW = (2*DATA_W)'(Q);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] a_comb;
  logic [DATA_W-1:0] b_comb;

  assign sum    = {1'b0, A} + {1'b0, B};
  // Add Q before subtracting so the difference never goes negative.
  assign diff   = (A >= B) ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + QD - {1'b0, B});
  assign a_comb = (sum >= QD) ? DATA_W'(sum - QD) : sum[DATA_W-1:0];
  assign b_comb = DATA_W'(({{(DATA_W-1){1'b0}}, diff} * {{DATA_W{1'b0}}, w}) % QW);

  logic [2*DATA_W-1:0] pipe_reg [BF_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < BF_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) pipe_reg[0] <= '0;
          else     pipe_reg[0] <= {a_comb, b_comb};
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) pipe_reg[gi] <= '0;
          else     pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign a = pipe_reg[BF_LAT-1][2*DATA_W-1:DATA_W];
  assign b = pipe_reg[BF_LAT-1][DATA_W-1:0];

endmodule

// File: rtl/intt_stage_ctrl_addr_delay_line.sv
// addr_delay_line: fixed-depth shift register that carries each pair's read
// addresses (plus a valid flag) forward to the cycle its butterfly result
// comes back, so write-back can reuse the same addresses in place.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears all taps)
//   in_valid, in_data   tap 0 input
//   out_valid, out_data value entered DEPTH cycles earlier
module addr_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Valid flag lives in the top bit of each tap.
  logic [WIDTH:0] tap_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) tap_reg[0] <= '0;
          else     tap_reg[0] <= {in_valid, in_data};
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) tap_reg[gi] <= '0;
          else     tap_reg[gi] <= tap_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = tap_reg[DEPTH-1][WIDTH];
  assign out_data  = tap_reg[DEPTH-1][WIDTH-1:0];

endmodule

// File: rtl/intt_stage_ctrl.sv
// intt_stage_ctrl: sequences one Gentleman-Sande INTT stage over an N = 2^LOG_N
// coefficient RAM. Issues one butterfly pair per cycle (reads + twiddle),
// forwards RAM/ROM data to the butterfly, and writes results back in place
// 1+BF_LAT cycles after each read.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, stage                  start pulse and stage index s (t = 2^s)
//   busy, done                    stage in progress / one-cycle completion pulse
//   rd_en, rd_addr_a/b, tw_addr   coefficient RAM and twiddle ROM read request
//   rd_data_a/b, tw_data          read data, valid one cycle after rd_en
//   bf_A, bf_B, bf_w, bf_valid    butterfly operands
//   bf_a, bf_b                    butterfly results
//   wr_en, wr_addr_a/b, wr_data_a/b  in-place write-back
module intt_stage_ctrl
  import intt_pkg::*;
#(
  parameter int LOG_N  = LOG_N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [stage_w(LOG_N)-1:0]  stage,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG_N-1:0]           rd_addr_a,
  output logic [LOG_N-1:0]           rd_addr_b,
  output logic [LOG_N-1:0]           tw_addr,
  input  logic [DATA_W-1:0]          rd_data_a,
  input  logic [DATA_W-1:0]          rd_data_b,
  input  logic [DATA_W-1:0]          tw_data,
  output logic [DATA_W-1:0]          bf_A,
  output logic [DATA_W-1:0]          bf_B,
  output logic [DATA_W-1:0]          bf_w,
  output logic                       bf_valid,
  input  logic [DATA_W-1:0]          bf_a,
  input  logic [DATA_W-1:0]          bf_b,
  output logic                       wr_en,
  output logic [LOG_N-1:0]           wr_addr_a,
  output logic [LOG_N-1:0]           wr_addr_b,
  output logic [DATA_W-1:0]          wr_data_a,
  output logic [DATA_W-1:0]          wr_data_b
);

  localparam int SW    = stage_w(LOG_N);
  localparam int DEPTH = 1 + BF_LAT;
  localparam int DCW   = $clog2(DEPTH + 1);

  localparam logic [LOG_N-1:0] LAST_K = LOG_N'((1 << (LOG_N - 1)) - 1);
  localparam logic [LOG_N:0]   N_VAL  = (LOG_N+1)'(1 << LOG_N);
  localparam logic [SW-1:0]    S_MAX  = SW'(LOG_N - 1);

  logic [1:0]       state_reg, state_next;
  logic [LOG_N-1:0] k_reg, k_next;
  logic [SW-1:0]    s_reg, s_next;
  logic [DCW-1:0]   drain_reg, drain_next;
  logic             bf_valid_reg;

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    s_next     = s_reg;
    drain_next = drain_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // Out-of-range stage indices saturate to the last stage.
          s_next     = (stage > S_MAX) ? S_MAX : stage;
          k_next     = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (k_reg == LAST_K) begin
          drain_next = '0;
          state_next = ST_DRAIN;
        end else begin
          k_next = k_reg + LOG_N'(1);
        end
      end
      ST_DRAIN: begin
        // DRAIN spans exactly the 1+BF_LAT cycles the final pair needs.
        if (drain_reg == DCW'(BF_LAT)) state_next = ST_FIN;
        else                           drain_next = drain_reg + DCW'(1);
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      s_reg        <= '0;
      drain_reg    <= '0;
      bf_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      s_reg        <= s_next;
      drain_reg    <= drain_next;
      bf_valid_reg <= rd_en;
    end
  end

  // Pair k lives in group g = k >> s at offset o = k mod t.
  logic [LOG_N-1:0] t_val, g_val, o_val, addr_a, addr_b, tw_val;

  always_comb begin
    t_val  = LOG_N'(1) << s_reg;
    g_val  = k_reg >> s_reg;
    o_val  = k_reg & (t_val - LOG_N'(1));
    addr_a = ((g_val << s_reg) << 1) | o_val;
    addr_b = addr_a + t_val;
    tw_val = LOG_N'((N_VAL >> s_reg) >> 1) + g_val;
  end

  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done      = (state_reg == ST_FIN);
  assign rd_en     = (state_reg == ST_RUN);
  // Addresses and data are held at zero whenever their strobe is low.
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_b : '0;
  assign tw_addr   = rd_en ? tw_val : '0;

  assign bf_valid  = bf_valid_reg;
  assign bf_A      = bf_valid_reg ? rd_data_a : '0;
  assign bf_B      = bf_valid_reg ? rd_data_b : '0;
  assign bf_w      = bf_valid_reg ? tw_data   : '0;

  logic [2*LOG_N-1:0] wr_addr_pair;

  addr_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (2 * LOG_N)
  ) u_addr_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en),
    .in_data   ({rd_addr_a, rd_addr_b}),
    .out_valid (wr_en),
    .out_data  (wr_addr_pair)
  );

  assign wr_addr_a = wr_addr_pair[2*LOG_N-1:LOG_N];
  assign wr_addr_b = wr_addr_pair[LOG_N-1:0];
  assign wr_data_a = wr_en ? bf_a : '0;
  assign wr_data_b = wr_en ? bf_b : '0;

endmodule

// File: tb/tb_intt_stage_ctrl.sv
// Testbench for intt_stage_ctrl with N=8, BF_LAT=3, a behavioural RAM/ROM and
// a gs_butterfly over Z_17. Expected pair order, timing and RAM contents come
// from a block-by-block model of each INTT stage.
module tb_intt_stage_ctrl;

  localparam int LOG_N  = 3;
  localparam int N      = 8;
  localparam int DATA_W = 30;
  localparam int BF_LAT = 3;
  localparam int Q      = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        stage = 2'd0;
  logic              busy, done, rd_en, bf_valid, wr_en;
  logic [LOG_N-1:0]  rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic [DATA_W-1:0] rd_data_a = '0, rd_data_b = '0, tw_data = '0;
  logic [DATA_W-1:0] bf_A, bf_B, bf_w, bf_a, bf_b, wr_data_a, wr_data_b;

  always #5 clk = ~clk;

  intt_stage_ctrl #(.LOG_N(LOG_N), .DATA_W(DATA_W), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
    .bf_A(bf_A), .bf_B(bf_B), .bf_w(bf_w), .bf_valid(bf_valid),
    .bf_a(bf_a), .bf_b(bf_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  gs_butterfly #(.DATA_W(DATA_W), .BF_LAT(BF_LAT), .Q(Q)) bfly (
    .clk(clk), .rst(rst), .A(bf_A), .B(bf_B), .w(bf_w), .a(bf_a), .b(bf_b)
  );

  // Behavioural memories
  logic [DATA_W-1:0] ram [N];
  logic [DATA_W-1:0] rom [N];
  logic [DATA_W-1:0] load_vals [N];
  logic              load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) ram <= load_vals;
    else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
      tw_data   <= rom[tw_addr];
    end
  end

  // Event monitor
  typedef struct { int cyc; int a; int b; int tw; } rd_ev_t;
  typedef struct { int cyc; int a; int b; int da; int db; } wr_ev_t;
  rd_ev_t rd_q[$];
  wr_ev_t wr_q[$];
  int     done_q[$];
  int     bv_q[$];
  int     busy_cnt = 0;
  int     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_en) rd_q.push_back('{cyc, int'(rd_addr_a), int'(rd_addr_b), int'(tw_addr)});
    if (wr_en) wr_q.push_back('{cyc, int'(wr_addr_a), int'(wr_addr_b), int'(wr_data_a), int'(wr_data_b)});
    if (done) done_q.push_back(cyc);
    if (bf_valid) bv_q.push_back(cyc);
    if (busy) busy_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int powmod(input int base, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * base) % Q;
    return r;
  endfunction

  function automatic int bitrev3(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  // Reference model: walk the stage block by block.
  int exp_a[$], exp_b[$], exp_tw[$];
  int exp_mem [N];

  task automatic model_stage(input int s);
    int se, t, nblk, i0, i1, w;
    int x [N];
    se   = (s >= LOG_N) ? LOG_N - 1 : s;
    t    = 1 << se;
    nblk = N / (2 * t);
    for (int i = 0; i < N; i++) x[i] = int'(ram[i]);
    exp_a.delete(); exp_b.delete(); exp_tw.delete();
    for (int blk = 0; blk < nblk; blk++) begin
      for (int j = 0; j < t; j++) begin
        i0 = blk * 2 * t + j;
        i1 = i0 + t;
        w  = int'(rom[nblk + blk]);
        exp_a.push_back(i0);
        exp_b.push_back(i1);
        exp_tw.push_back(nblk + blk);
        exp_mem[i0] = (x[i0] + x[i1]) % Q;
        exp_mem[i1] = (((x[i0] - x[i1] + Q) % Q) * w) % Q;
      end
    end
  endtask

  task automatic clear_events();
    rd_q.delete(); wr_q.delete(); done_q.delete(); bv_q.delete();
    busy_cnt = 0;
  endtask

  // Must be entered just after a rising edge; returns just after the rising
  // edge that follows done, so stages can be chained back to back.
  task automatic run_stage(input int s, input bit inject, input string tag);
    int  c0;
    bit  got_done;
    model_stage(s);
    clear_events();
    c0       = cyc;
    start    = 1'b1;
    stage    = 2'(s);
    got_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      start = inject && (cyc == c0 + 3);
      if (start) stage = (s == 0) ? 2'd2 : 2'd0;
      if (done_q.size() > 0) begin
        got_done = 1'b1;
        break;
      end
    end
    if (!got_done) chk({tag, " done_timeout"}, 0, 1);
    chk({tag, " rd_count"}, rd_q.size(), N / 2);
    for (int k = 0; k < N / 2 && k < rd_q.size(); k++) begin
      chk($sformatf("%s rd_cyc k%0d", tag, k), rd_q[k].cyc, c0 + 1 + k);
      chk($sformatf("%s rd_a k%0d", tag, k), rd_q[k].a, exp_a[k]);
      chk($sformatf("%s rd_b k%0d", tag, k), rd_q[k].b, exp_b[k]);
      chk($sformatf("%s tw k%0d", tag, k), rd_q[k].tw, exp_tw[k]);
    end
    chk({tag, " wr_count"}, wr_q.size(), N / 2);
    for (int k = 0; k < N / 2 && k < wr_q.size(); k++) begin
      chk($sformatf("%s wr_cyc k%0d", tag, k), wr_q[k].cyc, c0 + 2 + BF_LAT + k);
      chk($sformatf("%s wr_a k%0d", tag, k), wr_q[k].a, exp_a[k]);
      chk($sformatf("%s wr_b k%0d", tag, k), wr_q[k].b, exp_b[k]);
      chk($sformatf("%s wr_da k%0d", tag, k), wr_q[k].da, exp_mem[exp_a[k]]);
      chk($sformatf("%s wr_db k%0d", tag, k), wr_q[k].db, exp_mem[exp_b[k]]);
    end
    chk({tag, " bf_valid_count"}, bv_q.size(), N / 2);
    if (bv_q.size() > 0) chk({tag, " bf_valid_first"}, bv_q[0], c0 + 2);
    chk({tag, " done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, " done_cyc"}, done_q[0], c0 + N / 2 + 2 + BF_LAT);
    chk({tag, " busy_cycles"}, busy_cnt, N / 2 + 1 + BF_LAT);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s ram[%0d]", tag, i), int'(ram[i]), exp_mem[i]);
    $display("stage %s s=%0d start_cyc=%0d reads=%0d writes=%0d", tag, s, c0, rd_q.size(), wr_q.size());
  endtask

  // Reset asserted during cycle 6 of a stage.
  task automatic run_abort(input int s);
    int c0, late;
    clear_events();
    c0    = cyc;
    start = 1'b1;
    stage = 2'(s);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (cyc == c0 + 6);
    end
    late = 0;
    foreach (wr_q[i]) if (wr_q[i].cyc >= c0 + 7) late++;
    chk("abort late_writes", late, 0);
    chk("abort writes", wr_q.size(), 2);
    chk("abort done_count", done_q.size(), 0);
    chk("abort busy_cycles", busy_cnt, 6);
    chk("abort busy_after", int'(busy), 0);
    chk("abort wr_en_after", int'(wr_en), 0);
    $display("abort s=%0d start_cyc=%0d writes=%0d", s, c0, wr_q.size());
  endtask

  task automatic load_ram(input bit rnd);
    for (int i = 0; i < N; i++) load_vals[i] = rnd ? DATA_W'($urandom_range(0, Q - 1)) : DATA_W'(i);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  typedef struct { int stage; int k; int a; int b; int tw; } vec_t;
  vec_t vecs [12];

  task automatic table_check(input int s);
    foreach (vecs[i]) begin
      if (vecs[i].stage == s && vecs[i].k < rd_q.size()) begin
        chk($sformatf("table s%0d rd_a k%0d", s, vecs[i].k), rd_q[vecs[i].k].a, vecs[i].a);
        chk($sformatf("table s%0d rd_b k%0d", s, vecs[i].k), rd_q[vecs[i].k].b, vecs[i].b);
        chk($sformatf("table s%0d tw k%0d", s, vecs[i].k), rd_q[vecs[i].k].tw, vecs[i].tw);
      end
    end
  endtask

  initial begin
    vecs = '{
      '{0, 0, 0, 1, 4}, '{0, 1, 2, 3, 5}, '{0, 2, 4, 5, 6}, '{0, 3, 6, 7, 7},
      '{1, 0, 0, 2, 2}, '{1, 1, 1, 3, 2}, '{1, 2, 4, 6, 3}, '{1, 3, 5, 7, 3},
      '{2, 0, 0, 4, 1}, '{2, 1, 1, 5, 1}, '{2, 2, 2, 6, 1}, '{2, 3, 3, 7, 1}
    };
    // Inverse twiddles: psi = 3 has order 16 mod 17, psi^-1 = 6; bit-reversed table.
    for (int i = 0; i < N; i++) rom[i] = DATA_W'(powmod(6, bitrev3(i)));
    for (int i = 0; i < N; i++) load_vals[i] = DATA_W'(i);
    load_req = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    load_req = 1'b0;

    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset bf_valid", int'(bf_valid), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset rd_addr_b", int'(rd_addr_b), 0);
    chk("reset tw_addr", int'(tw_addr), 0);
    chk("reset wr_addr_b", int'(wr_addr_b), 0);

    // Full INTT on 0..7, stages chained with start right after each done.
    run_stage(0, 1'b0, "s0");
    table_check(0);
    run_stage(1, 1'b0, "s1");
    table_check(1);
    run_stage(2, 1'b0, "s2");
    table_check(2);

    // Out-of-range stage behaves as the last stage.
    run_stage(3, 1'b0, "clamp");
    table_check(2);

    // Start during busy must be ignored.
    run_stage(1, 1'b1, "inject");

    run_abort(0);

    for (int it = 0; it < 15; it++) begin
      load_ram(1'b1);
      run_stage(int'($urandom_range(0, 3)), 1'(($urandom & 3) == 0), $sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
